cpu_icache: RTL and testbench
=============================

# cpu_icache

Direct-mapped instruction cache between the CPU instruction bus (`cpui_*`) and the instruction memory bus (`imem_*`).
- Hits return data one cycle after the request, with back-to-back fetches at one per cycle.
- Misses refill a 4-word line with sequential single-outstanding memory reads, then return the requested word.
- Both buses use the codebase request/ack protocol: request is a one-cycle pulse, and ack is a one-cycle pulse carrying rdata.

## Interface
- `LINES`, default 64, number of cache lines. Must be a power of two and ≥2. IDX = log2(LINES).
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cpui_request`  in  1  CPU fetch request pulse.
- `cpui_addr`  in  32  fetch byte address. Bits [1:0] are ignored.
- `cpui_rdata`  out  32  instruction word, valid while `cpui_ack`=1.
- `cpui_ack`  out  1  fetch complete pulse.
- `invalidate`  in  1  clears all valid bits (e.g. FENCE.I / code load).
- `imem_request`  out  1  memory read request pulse.
- `imem_addr`  out  32  word-aligned memory address.
- `imem_rdata`  in  32  memory read data.
- `imem_ack`  in  1  memory read complete.
- `hit_count`  out  32  hit counter (see Configuration).
- `miss_count`  out  32  miss counter (see Configuration).

## Operation
- Address split: [3:2] word-in-line, [IDX+3:4] index, [31:IDX+4] tag.
- Storage:
  - Data RAM: LINES×4 words, synchronous read.
  - Tag RAM: LINES entries, synchronous read.
  - Valid bits: LINES flops.
- State machine:
  - IDLE: when `cpui_request`=1, read the tag/data RAMs at the index, latch the address, go to LOOKUP.
  - LOOKUP, hit (valid & tag match):
    - Assert `cpui_ack` with the addressed word.
    - If `cpui_request`=1 in the same cycle, accept it as a new lookup and stay in LOOKUP; otherwise go to IDLE.
  - LOOKUP, miss: go to FILL with word counter = 0 and pulse `imem_request` for line base + 0.
  - FILL:
    - On each `imem_ack`, write `imem_rdata` to data[index][counter]; if the counter equals the requested word, also capture it into the return register.
    - If counter < 3: increment it and pulse `imem_request` for the next word in the following cycle.
    - On the 4th ack: write the tag, set valid (unless suppressed), go to RESPOND.
  - RESPOND: assert `cpui_ack` with the captured word for one cycle, then go to IDLE.
- `cpui_request` in FILL or RESPOND is a protocol violation (the CPU keeps one fetch outstanding) and is ignored.
- `invalidate`:
  - Clears all valid bits at the next clock edge.
  - A LOOKUP in the same cycle compares against the pre-clear valid bits, so the hit is served.
  - If asserted at any point during a FILL, that fill still returns data but leaves the line invalid.
- `imem_ack` outside FILL is ignored.

## Timing
- Reset values:
  - `cpui_ack`=0, `cpui_rdata`=0.
  - `imem_request`=0, `imem_addr`=0.
  - State IDLE, all valid bits 0.
  - Counters 0.
- Reset mid-FILL abandons the fill. A late `imem_ack` arriving after reset is ignored.
- Hit: request at cycle T → `cpui_ack` at T+1. Sustained throughput is 1 fetch/cycle.
- Miss, with memory ack L cycles after request:
  - First `imem_request` at T+1.
  - Requests spaced L+1 cycles apart.
  - Last ack at T+4L+4.
  - `cpui_ack` at T+4L+5 (T+9 for L=1).
- `imem_request` and `cpui_ack` are registered single-cycle pulses. `imem_addr` holds its value until the next request.
- Counters wrap modulo 2^32.

## Configuration
- `CPU_ICACHE_STATS_EN` defined:
  - `hit_count` increments on each LOOKUP hit.
  - `miss_count` increments on each LOOKUP→FILL transition.
  - Both are cleared by reset only; `invalidate` does not affect them.
- Undefined: both counter outputs are tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset, fetch 0x100 with L=1 memory → `imem_addr` sequence 0x100, 0x104, 0x108, 0x10C; `cpui_ack` at T+9 with mem[0x100]; `miss_count`=1.
- Then fetch 0x108 → `cpui_ack` at T+1 with mem[0x108], no `imem_request`, `hit_count`=1.
- Requests for 0x100, 0x104, 0x108, 0x10C on consecutive cycles after fill → 4 consecutive acks with the correct words, no memory traffic.
- Conflict with LINES=64: fetch 0x100, 0x500, 0x100 (all index 0x10) → three misses, `miss_count`=3, each fill of 4 reads.
- Pulse `invalidate`, refetch 0x100 → miss. Separately, assert `invalidate` during a fill of 0x200, then refetch 0x200 → miss again.
- Assert reset during the 2nd word of a fill, send a stray `imem_ack` → no `cpui_ack`. A subsequent fetch of 0x100 misses and completes normally.

Source files
------------

// File: rtl/cpu_icache.sv
// cpu_icache: direct-mapped instruction cache, 4-word lines, single-outstanding refill.
// Optional hit/miss counters built only when CPU_ICACHE_STATS_EN is defined.
module cpu_icache #(
   parameter int LINES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpui_request,
   input  logic [31:0] cpui_addr,
   output logic [31:0] cpui_rdata,
   output logic        cpui_ack,
   input  logic        invalidate,
   output logic        imem_request,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int IDX = $clog2(LINES);
   localparam int TW  = 28 - IDX;
   typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;
   state_t r_state, w_next;
   logic [31:0]     r_data [LINES*4];
   logic [TW-1:0]   r_tag  [LINES];
   logic [LINES-1:0] r_valid;
   logic [31:2]     r_addr;
   logic [31:0]     r_rword, r_ret, r_maddr;
   logic [TW-1:0]   r_rtag;
   logic [1:0]      r_cnt;
   logic            r_req, r_inv;
   logic [IDX-1:0]  w_idx, w_ridx;
   logic            w_hit, w_miss, w_accept, w_fill_ack;
   logic            w_unused;
   assign w_unused   = &{1'b0, cpui_addr[1:0]};
   assign w_idx      = r_addr[IDX+3:4];
   assign w_ridx     = cpui_addr[IDX+3:4];
   // valid is sampled before any same-cycle invalidate takes effect
   assign w_hit      = r_state == LOOKUP && r_valid[w_idx] && r_rtag == r_addr[31:IDX+4];
   assign w_miss     = r_state == LOOKUP && !w_hit;
   assign w_accept   = cpui_request && (r_state == IDLE || w_hit);
   assign w_fill_ack = r_state == FILL && imem_ack;
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   always_comb begin
      w_next       = r_state;
      cpui_ack     = 1'b0;
      cpui_rdata   = '0;
      imem_request = r_req;
      imem_addr    = r_maddr;
      case (r_state)
         IDLE:    w_next = cpui_request ? LOOKUP : IDLE;
         LOOKUP: begin
            cpui_ack     = w_hit;
            cpui_rdata   = w_hit ? r_rword : '0;
            imem_request = !w_hit;
            imem_addr    = w_hit ? r_maddr : {r_addr[31:4], 4'b0};
            w_next       = !w_hit ? FILL : cpui_request ? LOOKUP : IDLE;
         end
         FILL:    w_next = (imem_ack && r_cnt == 2'd3) ? RESPOND : FILL;
         RESPOND: begin
            cpui_ack   = 1'b1;
            cpui_rdata = r_ret;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_addr  <= cpui_addr[31:2];
         r_rword <= r_data[{w_ridx, cpui_addr[3:2]}];
         r_rtag  <= r_tag[w_ridx];
      end
      if (w_fill_ack) begin
         r_data[{w_idx, r_cnt}] <= imem_rdata;
         if (r_cnt == r_addr[3:2]) r_ret <= imem_rdata;
         if (r_cnt == 2'd3) r_tag[w_idx] <= r_addr[31:IDX+4];
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= '0;
         r_req   <= 1'b0;
         r_maddr <= '0;
         r_cnt   <= '0;
         r_inv   <= 1'b0;
      end else begin
         r_req <= 1'b0;
         if (invalidate) r_valid <= '0;
         if (w_miss) begin
            r_cnt   <= '0;
            r_inv   <= 1'b0;
            r_maddr <= {r_addr[31:4], 4'b0};
         end
         // an invalidate seen anywhere in the fill keeps the refilled line invalid
         if (r_state == FILL && invalidate) r_inv <= 1'b1;
         if (w_fill_ack) begin
            if (r_cnt != 2'd3) begin
               r_cnt   <= r_cnt + 2'd1;
               r_req   <= 1'b1;
               r_maddr <= {r_addr[31:4], r_cnt + 2'd1, 2'b00};
            end else if (!(r_inv || invalidate)) begin
               r_valid[w_idx] <= 1'b1;
            end
         end
      end
   end
`ifdef CPU_ICACHE_STATS_EN
   logic [31:0] r_hits, r_misses;
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hits   <= '0;
         r_misses <= '0;
      end else begin
         if (w_hit)  r_hits   <= r_hits + 32'd1;
         if (w_miss) r_misses <= r_misses + 32'd1;
      end
   end
   assign hit_count  = r_hits;
   assign miss_count = r_misses;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cpu_icache.sv
// tb_cpu_icache: scoreboard bench for cpu_icache with a latency-configurable memory model.
module tb_cpu_icache;
`ifdef CPU_ICACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst, cpui_request, invalidate, cpui_ack, imem_request;
   logic        mem_ack, stray_ack;
   logic [31:0] cpui_addr, cpui_rdata, imem_addr, imem_rdata, hit_count, miss_count;
   logic [31:0] exp_q [$];
   logic [31:0] req_q [$];
   logic [31:0] m_addr;
   int cyc, n_req, n_acks, t_req, t_ack, n0, a0, t0;
   int mem_lat = 1;
   int n_chk, n_pass;
   cpu_icache #(.LINES(64)) dut (
      .clock(clk), .reset(rst),
      .cpui_request(cpui_request), .cpui_addr(cpui_addr),
      .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
      .invalidate(invalidate),
      .imem_request(imem_request), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(mem_ack | stray_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic [31:0] a);
      cpui_request = 1'b1;
      cpui_addr    = a;
      exp_q.push_back(mem_f(a));
      t_req = cyc;
      @(posedge clk);
      #1 cpui_request = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick(1);
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask
   initial begin
      mem_ack    = 1'b0;
      imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (imem_request) begin
            m_addr = imem_addr;
            req_q.push_back(m_addr);
            n_req++;
            repeat (mem_lat) @(posedge clk);
            #1 mem_ack = 1'b1;
            imem_rdata = mem_f(m_addr);
            @(posedge clk);
            #1 mem_ack = 1'b0;
         end
      end
   end
   always @(negedge clk) begin
      if (cpui_ack) begin
         t_ack = cyc;
         n_acks++;
         check("ack_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("rdata", cpui_rdata, exp_q.pop_front());
      end
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      rst = 1'b1; cpui_request = 1'b0; cpui_addr = '0; invalidate = 1'b0; stray_ack = 1'b0;
      tick(3);
      check("rst_ack", 32'(cpui_ack), 0);
      check("rst_rdata", cpui_rdata, 0);
      check("rst_ireq", 32'(imem_request), 0);
      check("rst_iaddr", imem_addr, 0);
      check("rst_hits", hit_count, 0);
      check("rst_misses", miss_count, 0);
      rst = 1'b0;
      tick(1);
      issue(32'h100); drain();
      check("miss_lat", t_ack - t_req, 9);
      check("miss_reqs", n_req, 4);
      for (int i = 0; i < 4; i++) check("miss_addr", req_q[i], 32'h100 + 4 * i);
      check("miss_cnt1", miss_count, STATS ? 1 : 0);
      n0 = n_req;
      issue(32'h10A); drain();
      check("hit_lat", t_ack - t_req, 1);
      check("hit_noreq", n_req - n0, 0);
      check("hit_cnt1", hit_count, STATS ? 1 : 0);
      a0 = n_acks; n0 = n_req; t0 = cyc;
      for (int i = 0; i < 4; i++) issue(32'h100 + 4 * i);
      drain();
      check("burst_acks", n_acks - a0, 4);
      check("burst_span", t_ack - t0, 4);
      check("burst_noreq", n_req - n0, 0);
      check("hit_cnt5", hit_count, STATS ? 5 : 0);
      n0 = n_req;
      issue(32'h500); drain();
      issue(32'h100); drain();
      check("conflict_reqs", n_req - n0, 8);
      check("miss_cnt3", miss_count, STATS ? 3 : 0);
      invalidate = 1'b1; tick(1); invalidate = 1'b0;
      mem_lat = 2; n0 = n_req;
      issue(32'h100); drain();
      check("inv_reqs", n_req - n0, 4);
      check("lat_L2", t_ack - t_req, 13);
      mem_lat = 1; n0 = n_req;
      issue(32'h200); tick(3);
      invalidate = 1'b1; tick(1); invalidate = 1'b0;
      drain();
      issue(32'h200); drain();
      check("fill_inv_reqs", n_req - n0, 8);
      n0 = n_req;
      issue(32'h204); drain();
      check("refill_hit_lat", t_ack - t_req, 1);
      check("refill_hit_noreq", n_req - n0, 0);
      issue(32'h208);
      invalidate = 1'b1; tick(1); invalidate = 1'b0;
      drain();
      check("inv_same_hit_lat", t_ack - t_req, 1);
      check("inv_same_noreq", n_req - n0, 0);
      issue(32'h208); drain();
      check("inv_same_refetch", n_req - n0, 4);
      check("hit_cnt7", hit_count, STATS ? 7 : 0);
      check("miss_cnt7", miss_count, STATS ? 7 : 0);
      mem_lat = 3; n0 = n_req; a0 = n_acks;
      issue(32'h300);
      for (int n = 0; n < 100 && n_req - n0 < 2; n++) tick(1);
      check("fill_2nd_req", n_req - n0, 2);
      rst = 1'b1;
      exp_q.delete();
      tick(1);
      rst = 1'b0;
      tick(5);
      stray_ack = 1'b1; tick(1); stray_ack = 1'b0;
      tick(3);
      check("rst_no_ack", n_acks - a0, 0);
      check("rst_no_req", n_req - n0, 2);
      check("rst_misses2", miss_count, 0);
      check("rst_hits2", hit_count, 0);
      mem_lat = 1; n0 = n_req;
      issue(32'h100); drain();
      check("post_rst_lat", t_ack - t_req, 9);
      check("post_rst_reqs", n_req - n0, 4);
      check("post_rst_miss", miss_count, STATS ? 1 : 0);
      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
